// File: rtl/uc_mem_streamer.sv
// Buffered source of initial unit clauses for the UC arbiter: the host loads signed
// literals, then the block streams them one per accepted cycle and pulses end-of-stream.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1024
`endif

module uc_mem_streamer #(
  parameter int LIT_W = $clog2(`LIT_IDX_MAX) + 1,
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    host_wr_en,
  input  logic signed [LIT_W-1:0] host_wr_lit,
  input  logic                    host_start,
  input  logic                    host_clear,
  input  logic                    uca_ready,
  input  logic                    conflict,
  output logic signed [LIT_W-1:0] mem2uca,
  output logic                    mem2uca_valid,
  output logic                    mem2uca_done,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow,
  output logic                    bad_lit,
  output logic                    busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE, ABORT} state_t;

  state_t                  state, state_next;
  logic signed [LIT_W-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0]        cnt_next;
  logic signed [LIT_W-1:0] lit_next;
  logic                    vld_next, done_next, ovf_next, bad_next, buf_we;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    cnt_next   = count;
    lit_next   = mem2uca;
    vld_next   = mem2uca_valid;
    done_next  = 1'b0;
    ovf_next   = overflow;
    bad_next   = bad_lit;
    buf_we     = 1'b0;
    if (host_clear) begin
      state_next = IDLE;
      rd_next    = '0;
      wr_next    = '0;
      cnt_next   = '0;
      lit_next   = '0;
      vld_next   = 1'b0;
      ovf_next   = 1'b0;
      bad_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lit_next = '0;
          vld_next = 1'b0;
          if (host_wr_en) begin
            if (host_wr_lit == '0) bad_next = 1'b1;
            else if (count == CNT_W'(DEPTH)) ovf_next = 1'b1;
            else begin
              buf_we   = 1'b1;
              wr_next  = wr_ptr + PTR_W'(1);
              cnt_next = count + CNT_W'(1);
            end
          end
          if (host_start) begin
            if (cnt_next == '0) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = STREAM;
              vld_next   = 1'b1;
              // An empty buffer means the coincident write is the head literal.
              lit_next   = (count == '0) ? host_wr_lit : buf_q[rd_ptr];
            end
          end
        end
        STREAM: begin
          if (conflict) begin
            state_next = ABORT;
            lit_next   = '0;
            vld_next   = 1'b0;
          end else if (mem2uca_valid && uca_ready) begin
            rd_next  = rd_ptr + PTR_W'(1);
            cnt_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state_next = DONE;
              lit_next   = '0;
              vld_next   = 1'b0;
              done_next  = 1'b1;
            end else begin
              lit_next = buf_q[rd_next];
            end
          end
        end
        DONE: begin
          lit_next = '0;
          vld_next = 1'b0;
          if (conflict) state_next = ABORT;
        end
        default: begin
          lit_next = '0;
          vld_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      mem2uca       <= '0;
      mem2uca_valid <= 1'b0;
      mem2uca_done  <= 1'b0;
      overflow      <= 1'b0;
      bad_lit       <= 1'b0;
    end else begin
      rd_ptr        <= rd_next;
      wr_ptr        <= wr_next;
      count         <= cnt_next;
      mem2uca       <= lit_next;
      mem2uca_valid <= vld_next;
      mem2uca_done  <= done_next;
      overflow      <= ovf_next;
      bad_lit       <= bad_next;
    end
  end

  // Storage is data only; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_ptr] <= host_wr_lit;
  end

  assign busy = (state == STREAM);

endmodule

// File: tb/tb_uc_mem_streamer.sv
// Directed bench for uc_mem_streamer: vector table for the basic streams plus
// hand-written sequences for overflow, empty start, conflict, reset and pointer wrap.
module tb_uc_mem_streamer;

  localparam int LIT_W = 11;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    host_wr_en, host_start, host_clear, uca_ready, conflict;
  logic signed [LIT_W-1:0] host_wr_lit;
  logic signed [LIT_W-1:0] mem2uca;
  logic                    mem2uca_valid, mem2uca_done, overflow, bad_lit, busy;
  logic [CNT_W-1:0]        count;

  int errors = 0;
  int checks = 0;

  uc_mem_streamer #(.LIT_W(LIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .host_wr_en(host_wr_en), .host_wr_lit(host_wr_lit),
    .host_start(host_start), .host_clear(host_clear), .uca_ready(uca_ready),
    .conflict(conflict), .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid),
    .mem2uca_done(mem2uca_done), .count(count), .overflow(overflow),
    .bad_lit(bad_lit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr; int lit; logic start; logic clear; logic ready;
    int e_vld; int e_lit; int e_done; int e_cnt; int e_busy;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    host_wr_en = 1'b0; host_wr_lit = '0; host_start = 1'b0;
    host_clear = 1'b0; uca_ready = 1'b0; conflict = 1'b0;
  endtask

  task automatic wr(input int lit);
    quiet();
    host_wr_en = 1'b1; host_wr_lit = LIT_W'(lit);
    step();
    quiet();
  endtask

  task automatic clear();
    quiet(); host_clear = 1'b1; step(); quiet();
  endtask

  task automatic chk_out(input string nm, input int vld, input int lit, input int done,
                         input int cnt, input int bsy);
    chk({nm, ".vld"}, mem2uca_valid, vld);
    chk({nm, ".lit"}, mem2uca, lit);
    chk({nm, ".done"}, mem2uca_done, done);
    chk({nm, ".cnt"}, count, cnt);
    chk({nm, ".busy"}, busy, bsy);
  endtask

  // Load n literals base..base+n-1, start, drain with ready held, expect a done pulse.
  task automatic load_stream(input string nm, input int n, input int base);
    for (int i = 0; i < n; i++) wr(base + i);
    chk({nm, ".loaded"}, count, n);
    host_start = 1'b1; step(); quiet();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.lit%0d", nm, i), mem2uca_valid ? int'(mem2uca) : -9999, base + i);
      uca_ready = 1'b1; step(); quiet();
    end
    chk_out({nm, ".end"}, 0, 0, 1, 0, 0);
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    step();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.ovf", overflow, 0);
    chk("reset.bad", bad_lit, 0);
    rst_n = 1'b1;

    //          wr  lit start clr rdy | vld lit done cnt busy
    tbl[0]  = '{1,   3, 0, 0, 0,  0,  0, 0, 1, 0};
    tbl[1]  = '{1,  -7, 0, 0, 0,  0,  0, 0, 2, 0};
    tbl[2]  = '{1,  12, 0, 0, 0,  0,  0, 0, 3, 0};
    tbl[3]  = '{0,   0, 1, 0, 1,  1,  3, 0, 3, 1};
    tbl[4]  = '{0,   0, 0, 0, 1,  1, -7, 0, 2, 1};
    tbl[5]  = '{0,   0, 0, 0, 1,  1, 12, 0, 1, 1};
    tbl[6]  = '{0,   0, 0, 0, 1,  0,  0, 1, 0, 0};
    tbl[7]  = '{0,   0, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[8]  = '{0,   0, 0, 1, 0,  0,  0, 0, 0, 0};
    tbl[9]  = '{1,   3, 0, 0, 0,  0,  0, 0, 1, 0};
    tbl[10] = '{1,  -7, 0, 0, 0,  0,  0, 0, 2, 0};
    tbl[11] = '{1,  12, 0, 0, 0,  0,  0, 0, 3, 0};
    tbl[12] = '{0,   0, 1, 0, 0,  1,  3, 0, 3, 1};
    tbl[13] = '{0,   0, 0, 0, 1,  1, -7, 0, 2, 1};
    tbl[14] = '{0,   0, 0, 0, 0,  1, -7, 0, 2, 1};
    tbl[15] = '{0,   0, 0, 0, 0,  1, -7, 0, 2, 1};
    tbl[16] = '{0,   0, 0, 0, 1,  1, 12, 0, 1, 1};
    tbl[17] = '{0,   0, 0, 0, 1,  0,  0, 1, 0, 0};
    tbl[18] = '{0,   0, 0, 0, 0,  0,  0, 0, 0, 0};
    tbl[19] = '{0,   0, 0, 1, 0,  0,  0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      quiet();
      host_wr_en  = tbl[i].wr;
      host_wr_lit = LIT_W'(tbl[i].lit);
      host_start  = tbl[i].start;
      host_clear  = tbl[i].clear;
      uca_ready   = tbl[i].ready;
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_lit, tbl[i].e_done,
              tbl[i].e_cnt, tbl[i].e_busy);
    end
    quiet();

    // Overflow, zero literal, and full-buffer drain (also wraps both pointers)
    for (int i = 0; i < 65; i++) wr(i + 1);
    chk("ovf.cnt", count, 64);
    chk("ovf.flag", overflow, 1);
    chk("ovf.bad", bad_lit, 0);
    wr(0);
    chk("zero.bad", bad_lit, 1);
    chk("zero.cnt", count, 64);
    host_start = 1'b1; step(); quiet();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("full.lit%0d", i), mem2uca_valid ? int'(mem2uca) : -9999, i + 1);
      uca_ready = 1'b1; step(); quiet();
    end
    chk_out("full.end", 0, 0, 1, 0, 0);
    step();
    chk_out("full.after", 0, 0, 0, 0, 0);
    chk("full.ovf_sticky", overflow, 1);
    clear();
    chk("clr.ovf", overflow, 0);
    chk("clr.bad", bad_lit, 0);

    // Empty start goes straight to DONE; start and writes ignored there
    host_start = 1'b1; step(); quiet();
    chk_out("empty.start", 0, 0, 1, 0, 0);
    step();
    chk_out("empty.next", 0, 0, 0, 0, 0);
    host_start = 1'b1; host_wr_en = 1'b1; host_wr_lit = 11'sd5; step(); quiet();
    chk_out("done.ignore", 0, 0, 0, 0, 0);
    chk("done.bad", bad_lit, 0);
    clear();

    // Write coinciding with start is included in the stream
    wr(4);
    host_wr_en = 1'b1; host_wr_lit = 11'sd5; host_start = 1'b1; step(); quiet();
    chk_out("wrstart.a", 1, 4, 0, 2, 1);
    uca_ready = 1'b1; step();
    chk_out("wrstart.b", 1, 5, 0, 1, 1);
    step(); quiet();
    chk_out("wrstart.end", 0, 0, 1, 0, 0);
    clear();
    host_wr_en = 1'b1; host_wr_lit = -11'sd9; host_start = 1'b1; step(); quiet();
    chk_out("wrstart.empty", 1, -9, 0, 1, 1);
    clear();

    // Conflict mid-stream aborts without done
    for (int i = 0; i < 5; i++) wr(10 + i);
    host_start = 1'b1; step(); quiet();
    uca_ready = 1'b1; step(); step(); quiet();
    chk_out("cfl.pre", 1, 12, 0, 3, 1);
    conflict = 1'b1; step(); quiet();
    chk("cfl.vld", mem2uca_valid, 0);
    chk("cfl.done", mem2uca_done, 0);
    chk("cfl.busy", busy, 0);
    uca_ready = 1'b1; step(); quiet();
    chk("abort.vld", mem2uca_valid, 0);
    chk("abort.done", mem2uca_done, 0);
    clear();
    chk("cfl.clr_cnt", count, 0);
    load_stream("cfl.reload", 2, 21);
    clear();

    // Conflict on the final transfer suppresses done
    wr(-3);
    host_start = 1'b1; step(); quiet();
    uca_ready = 1'b1; conflict = 1'b1; step(); quiet();
    chk_out("cfl_last.a", 0, 0, 0, count, 0);
    step();
    chk("cfl_last.b", mem2uca_done, 0);
    clear();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) wr(30 + i);
    host_start = 1'b1; step(); quiet();
    uca_ready = 1'b1; step();
    host_wr_en = 1'b1; host_wr_lit = 11'sd0; host_clear = 1'b0;
    rst_n = 1'b0; step(); quiet();
    chk_out("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid.bad", bad_lit, 0);
    rst_n = 1'b1;

    load_stream("wrap1", 40, 100);
    clear();
    load_stream("wrap2", 40, -200);
    clear();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
